// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle for the sequential ALU. The master
//                side (execute stage) drives start, alucont and the operands.
//                The slave side (alu_seq) returns busy/done, the result and
//                the condition flags.
//  Ports       : none (signal bundle only). Parameter WIDTH sets the operand
//                and result width.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [2:0]       alucont;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic             divzero;

    modport master (
        output start, alucont, a, b,
        input  busy, done, result, zero, carry, overflow, divzero
    );

    modport slave (
        input  start, alucont, a, b,
        output busy, done, result, zero, carry, overflow, divzero
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with a start/busy/done handshake.
//                AND/OR/ADD/SUB/SLT finish one cycle after start.
//                MUL (shift-add), DIVU and REMU (restoring division) iterate
//                one bit per cycle for WIDTH cycles.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous, active-high; aborts any op in flight
//                bus   - alu_seq_if.slave: start/alucont/a/b in,
//                        busy/done/result/zero/carry/overflow/divzero out
//  Revision    : 1.0  initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  wire logic clk,
    input  wire logic reset,
    alu_seq_if.slave  bus
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_ADD  = 3'b010;
    localparam logic [2:0] c_OP_MUL  = 3'b011;
    localparam logic [2:0] c_OP_DIVU = 3'b100;
    localparam logic [2:0] c_OP_REMU = 3'b101;
    localparam logic [2:0] c_OP_SUB  = 3'b110;
    localparam logic [2:0] c_OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [2:0]        op_q,       op_d;
    // acc: MUL partial product / DIV partial remainder
    // x  : MUL multiplier (shifts right) / DIV dividend-becoming-quotient
    // y  : MUL multiplicand (shifts left) / DIV divisor
    logic [WIDTH-1:0]  acc_q,      acc_d;
    logic [WIDTH-1:0]  x_q,        x_d;
    logic [WIDTH-1:0]  y_q,        y_d;
    logic [CNTW-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]  result_q,   result_d;
    logic              zero_q,     zero_d;
    logic              carry_q,    carry_d;
    logic              overflow_q, overflow_d;
    logic              divzero_q,  divzero_d;

    // ---------------- single-cycle datapath ----------------
    logic              w_is_sub;
    logic [WIDTH-1:0]  w_bx;
    logic [WIDTH:0]    w_sum;
    logic              w_ovf;
    logic              w_slt;
    logic              w_is_arith;
    logic              w_is_multi;
    logic [WIDTH-1:0]  w_single_res;

    // alucont[2] marks the subtracting forms (110 SUB, 111 SLT) whenever the
    // op is arithmetic; DIVU/REMU also have bit 2 set but never use the adder.
    assign w_is_sub   = bus.alucont[2];
    assign w_bx       = w_is_sub ? ~bus.b : bus.b;
    assign w_sum      = {1'b0, bus.a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, w_is_sub};
    assign w_ovf      = (bus.a[WIDTH-1] == w_bx[WIDTH-1]) &&
                        (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
    // Sign of the difference corrected by overflow gives the true signed a<b.
    assign w_slt      = w_sum[WIDTH-1] ^ w_ovf;
    assign w_is_arith = (bus.alucont == c_OP_ADD) || (bus.alucont == c_OP_SUB) ||
                        (bus.alucont == c_OP_SLT);
    assign w_is_multi = (bus.alucont == c_OP_MUL) || (bus.alucont == c_OP_DIVU) ||
                        (bus.alucont == c_OP_REMU);

    always_comb begin
        w_single_res = '0;
        case (bus.alucont)
            c_OP_AND: w_single_res = bus.a & bus.b;
            c_OP_OR:  w_single_res = bus.a | bus.b;
            c_OP_ADD,
            c_OP_SUB: w_single_res = w_sum[WIDTH-1:0];
            c_OP_SLT: w_single_res = {{(WIDTH-1){1'b0}}, w_slt};
            default:  w_single_res = '0;
        endcase
    end

    // ---------------- iterative datapath ----------------
    logic [WIDTH-1:0]  w_mul_acc;
    logic [WIDTH:0]    w_rsh;
    logic [WIDTH:0]    w_trial;
    logic              w_ge;

    assign w_mul_acc = acc_q + (x_q[0] ? y_q : {WIDTH{1'b0}});
    assign w_rsh     = {acc_q, x_q[WIDTH-1]};
    assign w_trial   = w_rsh - {1'b0, y_q};
    // A zero divisor always "fits", which yields an all-ones quotient and
    // leaves the dividend in the remainder without any special case.
    assign w_ge      = ~w_trial[WIDTH];

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= c_OP_AND;
            acc_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            zero_q     <= 1'b1;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            divzero_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            divzero_q  <= divzero_d;
        end
    end

    // ---------------- next state / datapath control ----------------
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        acc_d      = acc_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        divzero_d  = divzero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (w_is_multi) begin
                        // MUL and DIV share the same operand loading.
                        op_d    = bus.alucont;
                        acc_d   = '0;
                        x_d     = bus.a;
                        y_d     = bus.b;
                        cnt_d   = CNTW'(WIDTH);
                        state_d = S_BUSY;
                    end else begin
                        result_d   = w_single_res;
                        zero_d     = (w_single_res == '0);
                        carry_d    = w_is_arith & w_sum[WIDTH];
                        overflow_d = w_is_arith & w_ovf;
                        divzero_d  = 1'b0;
                        state_d    = S_DONE;
                    end
                end
            end

            S_BUSY: begin
                if (op_q == c_OP_MUL) begin
                    acc_d = w_mul_acc;
                    x_d   = x_q >> 1;
                    y_d   = y_q << 1;
                end else begin
                    acc_d = w_ge ? w_trial[WIDTH-1:0] : w_rsh[WIDTH-1:0];
                    x_d   = {x_q[WIDTH-2:0], w_ge};
                end
                cnt_d = cnt_q - CNTW'(1);

                if (cnt_q == CNTW'(1)) begin
                    case (op_q)
                        c_OP_MUL:  result_d = w_mul_acc;
                        c_OP_DIVU: result_d = x_d;
                        default:   result_d = acc_d;
                    endcase
                    zero_d     = (result_d == '0);
                    carry_d    = 1'b0;
                    overflow_d = 1'b0;
                    divzero_d  = (op_q != c_OP_MUL) && (y_q == '0);
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == S_BUSY);
    assign bus.done     = (state_q == S_DONE);
    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = overflow_q;
    assign bus.divzero  = divzero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Self-checking bench for alu_seq. An 8-bit instance runs the
//                directed cases and a randomized sweep against an arithmetic
//                reference model; a 16-bit instance checks wider latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_seq;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_r;
    logic       exp_z, exp_c, exp_v, exp_dz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: results and flags straight from integer arithmetic.
    task automatic model8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic z, output logic c,
                          output logic v, output logic dz);
        int ua, ub, sa, sb, s;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        r = 8'h00; c = 1'b0; v = 1'b0; dz = 1'b0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin
                s = ua + ub; r = 8'(s); c = (s > 255);
                s = sa + sb; v = (s > 127) || (s < -128);
            end
            3'd6: begin
                r = 8'(ua - ub); c = (ua >= ub);
                s = sa - sb; v = (s > 127) || (s < -128);
            end
            3'd7: begin
                r = (sa < sb) ? 8'd1 : 8'd0; c = (ua >= ub);
                s = sa - sb; v = (s > 127) || (s < -128);
            end
            3'd3: r = 8'((ua * ub) % 256);
            3'd4: begin dz = (ub == 0); r = dz ? 8'hFF : 8'(ua / ub); end
            default: begin dz = (ub == 0); r = dz ? a : 8'(ua % ub); end
        endcase
        z = (r == 8'h00);
    endtask

    // One full transaction on the 8-bit unit. ign_cyc (1..8) raises a stray
    // start in that BUSY cycle; a stray start is always raised in DONE.
    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int ign_cyc);
        logic [7:0] r;
        logic z, c, v, dz;
        int lat;
        model8(op, a, b, r, z, c, v, dz);
        lat = (op == 3'd3 || op == 3'd4 || op == 3'd5) ? 9 : 1;
        bus8.start = 1'b1; bus8.alucont = op; bus8.a = a; bus8.b = b;
        tick();
        bus8.start = 1'b0;
        bus8.alucont = 3'($urandom); bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        for (int cyc = 1; cyc < lat; cyc++) begin
            chk("busy_iter", 32'(bus8.busy), 32'd1);
            chk("done_early", 32'(bus8.done), 32'd0);
            chk("result_hold_busy", 32'(bus8.result), 32'(exp_r));
            bus8.start = (cyc == ign_cyc);
            tick();
        end
        bus8.start = 1'b0;
        chk("done", 32'(bus8.done), 32'd1);
        chk("busy_at_done", 32'(bus8.busy), 32'd0);
        chk("result", 32'(bus8.result), 32'(r));
        chk("zero", 32'(bus8.zero), 32'(z));
        chk("carry", 32'(bus8.carry), 32'(c));
        chk("overflow", 32'(bus8.overflow), 32'(v));
        chk("divzero", 32'(bus8.divzero), 32'(dz));
        exp_r = r; exp_z = z; exp_c = c; exp_v = v; exp_dz = dz;
        // Stray start during DONE must be ignored.
        bus8.start = 1'b1; bus8.alucont = 3'd2; bus8.a = 8'h11; bus8.b = 8'h22;
        tick();
        bus8.start = 1'b0;
        chk("done_one_cycle", 32'(bus8.done), 32'd0);
        chk("idle_not_busy", 32'(bus8.busy), 32'd0);
        chk("result_hold_idle", 32'(bus8.result), 32'(exp_r));
    endtask

    initial begin
        int cyc;
        logic [15:0] a16, b16;

        bus8.start = 1'b0;  bus8.alucont = 3'd0;  bus8.a = '0;  bus8.b = '0;
        bus16.start = 1'b0; bus16.alucont = 3'd0; bus16.a = '0; bus16.b = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_result", 32'(bus8.result), 32'd0);
        chk("rst_zero", 32'(bus8.zero), 32'd1);
        chk("rst_carry", 32'(bus8.carry), 32'd0);
        chk("rst_overflow", 32'(bus8.overflow), 32'd0);
        chk("rst_divzero", 32'(bus8.divzero), 32'd0);
        chk("rst_result16", 32'(bus16.result), 32'd0);
        exp_r = 8'h00;

        // Directed cases
        run8(3'd2, 8'h7F, 8'h01, 0);    // ADD overflow
        run8(3'd6, 8'h05, 8'h05, 0);    // SUB to zero
        run8(3'd7, 8'h80, 8'h01, 0);    // SLT negative < positive
        run8(3'd7, 8'h7F, 8'h80, 0);    // SLT with overflow
        run8(3'd3, 8'h0C, 8'h0B, 4);    // MUL with stray start in cycle 4
        run8(3'd4, 8'd100, 8'd7, 0);    // DIVU
        run8(3'd5, 8'd100, 8'd7, 0);    // REMU
        run8(3'd4, 8'h2A, 8'h00, 0);    // DIVU by zero
        run8(3'd5, 8'h2A, 8'h00, 3);    // REMU by zero
        run8(3'd0, 8'hF0, 8'h3C, 0);    // AND clears divzero
        run8(3'd1, 8'h00, 8'h00, 0);    // OR zero
        run8(3'd3, 8'hFF, 8'hFF, 0);    // MUL wrap

        // Reset in cycle 4 of a MUL
        bus8.start = 1'b1; bus8.alucont = 3'd3; bus8.a = 8'h0C; bus8.b = 8'h0B;
        tick();
        bus8.start = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_busy", 32'(bus8.busy), 32'd0);
        chk("midrst_done", 32'(bus8.done), 32'd0);
        chk("midrst_result", 32'(bus8.result), 32'd0);
        chk("midrst_zero", 32'(bus8.zero), 32'd1);
        chk("midrst_divzero", 32'(bus8.divzero), 32'd0);
        exp_r = 8'h00;
        run8(3'd2, 8'd3, 8'd4, 0);

        // Randomized sweep
        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run8(3'($urandom_range(0, 7)), ra, rb, int'($urandom_range(0, 8)));
        end

        // 16-bit instance: latency and wrap-to-zero product
        bus16.start = 1'b1; bus16.alucont = 3'd3; bus16.a = 16'h0100; bus16.b = 16'h0100;
        tick();
        bus16.start = 1'b0;
        cyc = 1;
        while (!bus16.done && cyc < 40) begin tick(); cyc++; end
        chk("w16_mul_latency", 32'(cyc), 32'd17);
        chk("w16_mul_result", 32'(bus16.result), 32'h0000);
        chk("w16_mul_zero", 32'(bus16.zero), 32'd1);
        tick();

        a16 = 16'($urandom);
        b16 = 16'($urandom_range(1, 65535));
        bus16.start = 1'b1; bus16.alucont = 3'd4; bus16.a = a16; bus16.b = b16;
        tick();
        bus16.start = 1'b0;
        cyc = 1;
        while (!bus16.done && cyc < 40) begin tick(); cyc++; end
        chk("w16_div_latency", 32'(cyc), 32'd17);
        chk("w16_div_result", 32'(bus16.result), 32'(a16 / b16));
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's combinational 8-bit ALU.
- Keeps the same 3-bit alucont encoding for AND/OR/ADD/SUB/SLT and reuses the three spare codes for multi-cycle MUL, DIVU and REMU.
- Adds a start/busy/done handshake and a full condition-flag set.
- Sits in each core's execute stage. The core stalls while busy is high.

Parameters:
- WIDTH, 8, operand/result width in bits, ≥ 4.
- CNTW, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- alucont  input  3  operation select, sampled with start
- a  input  WIDTH  operand A, sampled with start
- b  input  WIDTH  operand B, sampled with start
- busy  output  1  high while a multi-cycle op iterates
- done  output  1  one-cycle pulse: result and flags valid
- result  output  WIDTH  registered result, held until next accepted start
- zero  output  1  result == 0
- carry  output  1  carry-out, ADD/SUB only
- overflow  output  1  signed overflow, ADD/SUB only
- divzero  output  1  DIVU/REMU with b == 0

Behaviour:
- Reset:
  - Synchronous reset has priority over everything else; it aborts any op in flight.
  - State goes to IDLE.
  - busy=0, done=0, result=0, carry=0, overflow=0, divzero=0, zero=1.
- alucont encoding:
  - 000 AND; 001 OR; 010 ADD; 110 SUB (a+~b+1); 111 SLT.
  - 011 MUL, low WIDTH bits of the unsigned product.
  - 100 DIVU quotient; 101 REMU remainder.
- SLT:
  - Result is 1 iff a < b, signed. Compute it as sum[WIDTH-1] XOR overflow so it is correct on overflow.
  - Result is zero-extended to WIDTH.
- States: IDLE, BUSY, DONE.
- Single-cycle ops (AND, OR, ADD, SUB, SLT):
  - start in IDLE registers result and flags at the same edge and goes to DONE.
  - done=1 for the next cycle (latency 1), then IDLE. busy stays 0.
- Multi-cycle ops (MUL, DIVU, REMU):
  - start in IDLE latches operands, loads counter=WIDTH and goes to BUSY. busy=1 from the next cycle.
  - One iteration per cycle: shift-add for MUL, restoring shift-subtract for DIV.
  - After exactly WIDTH BUSY cycles, the last iteration edge writes result and flags and goes to DONE. busy drops as done rises.
  - done occurs in cycle WIDTH+1 after the start edge. With WIDTH=8, done is in cycle 9.
- DONE lasts exactly one cycle, then IDLE. start is not accepted in DONE, so back-to-back ops are one per two cycles minimum.
- start while in BUSY or DONE is ignored. There is no queueing, and latched operands are unaffected.
- Flags:
  - zero is updated for every op.
  - carry and overflow are updated for ADD/SUB/SLT and cleared for all other ops.
  - divzero is set only for DIVU/REMU with b == 0, and cleared by every other completed op.
- Divide by zero:
  - Still takes the full WIDTH iterations with no early exit.
  - Quotient = all ones; remainder = a.
- Outputs change only at edges that complete an op, or at reset. Between ops, result and flags hold.
- a, b and alucont may change freely after the start edge.

Test Plan:
- ADD overflow: WIDTH=8, ADD a=0x7F, b=0x01 → next cycle done=1, result=0x80, overflow=1, carry=0, zero=0, busy never 1.
- SUB and SLT:
  - SUB a=0x05, b=0x05 → result=0x00, zero=1, carry=1, overflow=0.
  - SLT a=0x80, b=0x01 → result=0x01.
  - SLT a=0x7F, b=0x80 → result=0x00 (overflow-correct).
- MUL handshake: MUL a=0x0C, b=0x0B → busy=1 cycles 1–8, done=1 in cycle 9, result=0x84, carry=0, overflow=0. A second start in cycle 4 with different operands is ignored and the result is unchanged.
- DIVU/REMU:
  - DIVU a=100, b=7 → result=14 in cycle 9.
  - REMU a=100, b=7 → result=2.
  - DIVU a=0x2A, b=0 → result=0xFF, divzero=1, done in cycle 9.
  - A following AND clears divzero.
- Reset mid-operation: start MUL, assert reset in cycle 4 → next cycle busy=0, done=0, result=0, zero=1. A later ADD 3+4 completes normally with result=7 and done one cycle after start.
- WIDTH=16 regression: MUL 0x0100 × 0x0100 → result=0x0000, zero=1, done in cycle 17.
